hazard_sb: RTL and testbench
============================

HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- AW, 5, register-address width.
- MUL_LAT, 2, E-stage stall cycles for multiply, must be >=1.
- DIV_LAT, 32, E-stage stall cycles for divide, must be >=1.
- CNT_W, 16, width of the stall performance counter.
- BR_STALL_EN, 1, enables branch-operand stall.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- rsD, rtD, in, AW, D-stage sources.
- branchD, in, 1, branch in D.
- forwardaD, forwardbD, out, 1, forward M result to D comparator.
- stallF, stallD, out, 1, hold F and D.
- rsE, rtE, writeregE, in, AW, E-stage regs.
- regwriteE, in, 1, E writes a register.
- memtoregE, in, 2, nonzero means E result comes late (mem/hi/lo).
- mdstartE, in, 1, multi-cycle op present in E.
- mdtypeE, in, 1, 0=mul, 1=div.
- forwardaE, forwardbE, out, 2, 00 regfile, 10 from M, 01 from W.
- stallE, flushE, out, 1, hold E or bubble E.
- writeregM, in, AW, M-stage destination.
- regwriteM, in, 1, M-stage write enable.
- memtoregM, in, 2, M-stage late-result code.
- writeregW, in, AW, W-stage destination.
- regwriteW, in, 1, W-stage write enable.
- stallM, stallW, out, 1, hold M/W.
- md_busy, out, 1, multi-cycle unit occupied.
- md_done, out, 1, one-cycle completion pulse.
- stall_cnt, out, CNT_W, saturating count of stallD cycles.

Function
REQ-004 forwardaD SHALL be 1 iff rsD!=0 and rsD==writeregM and regwriteM; forwardbD is the same with rtD.
REQ-005 forwardaE SHALL be 10 if rsE!=0, rsE==writeregM and regwriteM; else 01 if rsE!=0, rsE==writeregW and regwriteW; else 00. forwardbE is the same with rtE. M has priority over W.
REQ-006 lwstall SHALL be memtoregE!=0 and regwriteE and writeregE!=0 and (writeregE==rsD or writeregE==rtD).
REQ-007 brstall SHALL be BR_STALL_EN and branchD and (either of the following holds):
- regwriteE, writeregE!=0, and writeregE matching rsD or rtD.
- memtoregM!=0, regwriteM, writeregM!=0, and writeregM matching rsD or rtD.
REQ-008 The multi-cycle FSM SHALL have states IDLE, BUSY and DONE, plus a down-counter cnt wide enough for max(MUL_LAT,DIV_LAT).
REQ-009 In IDLE with mdstartE=1, cnt SHALL load (mdtypeE?DIV_LAT:MUL_LAT)-1, and the next state is DONE if that value is 0, else BUSY.
REQ-010 In BUSY, cnt SHALL decrement each cycle, and the next state is DONE when cnt==1.
REQ-011 In DONE, next state SHALL be IDLE unconditionally; mdstartE is ignored in DONE because the same instruction still occupies E.
REQ-012 stall_md SHALL be combinational: (IDLE and mdstartE) or BUSY. E is therefore held exactly LAT cycles including the issue cycle.
REQ-013 md_busy SHALL equal stall_md, and md_done SHALL be 1 only in DONE.
REQ-014 mdtypeE SHALL be sampled only on the issue cycle; later changes do not alter the latency.
REQ-015 The stall and flush outputs SHALL be:
- stallD = lwstall or brstall or stall_md.
- stallF = stallD.
- stallE = stallM = stallW = stall_md.
- flushE = (lwstall or brstall) and not stall_md.
REQ-016 stall_cnt SHALL increment by 1 on each rising clk edge where stallD=1, and hold at all-ones (saturate, no wrap).
REQ-017 Register 0 SHALL never cause a forward, lwstall or brstall.

Reset
REQ-018 rst=1 SHALL immediately force the FSM to IDLE, cnt=0 and stall_cnt=0, with md_busy=0 and md_done=0 unless mdstartE=1 (REQ-012 then applies combinationally).
REQ-019 A reset asserted mid-BUSY SHALL abort the operation with no md_done pulse. After release, mdstartE=1 starts a new full-latency operation.
REQ-020 Combinational forward outputs SHALL depend only on the current inputs, during reset as well.

Verification
REQ-021 Forward priority: rsE=rtE=5, writeregM=writeregW=5, regwriteM=regwriteW=1 -> forwardaE=forwardbE=10; with regwriteM=0 -> 01; with rsE=rtE=0 -> 00.
REQ-022 Load-use: memtoregE=01, regwriteE=1, writeregE=8, rsD=8 -> stallF=stallD=flushE=1, stallE=0, stall_cnt +1 per cycle.
REQ-023 Divide, DIV_LAT=32: mdstartE=1 and mdtypeE=1 held -> stallE=1 for exactly 32 cycles, then md_done=1 for 1 cycle with stallE=0, and no re-trigger. MUL_LAT=1: stall for 1 cycle, then DONE.
REQ-024 Simultaneous events: lwstall and stall_md both active -> stallD=1, flushE=0, stallE=1. Branch with rsD==writeregE and regwriteE=1 -> brstall; with BR_STALL_EN=0 -> no stall.
REQ-025 Reset mid-BUSY at cycle 10 of a divide -> md_busy=0 and cnt=0 asynchronously, no md_done. After reissue, a full 32-cycle stall follows.
REQ-026 CNT_W=4: hold stallD=1 for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_sb.sv
// Pipeline hazard unit: operand forwarding, load-use/branch interlocks, a multi-cycle
// mul/div occupancy FSM and a saturating counter of decode-stall cycles.
module hazard_sb #(
    parameter int AW          = 5,
    parameter int MUL_LAT     = 2,
    parameter int DIV_LAT     = 32,
    parameter int CNT_W       = 16,
    parameter bit BR_STALL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rsD,
    input  logic [AW-1:0]    rtD,
    input  logic             branchD,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic             stallF,
    output logic             stallD,
    input  logic [AW-1:0]    rsE,
    input  logic [AW-1:0]    rtE,
    input  logic [AW-1:0]    writeregE,
    input  logic             regwriteE,
    input  logic [1:0]       memtoregE,
    input  logic             mdstartE,
    input  logic             mdtypeE,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallE,
    output logic             flushE,
    input  logic [AW-1:0]    writeregM,
    input  logic             regwriteM,
    input  logic [1:0]       memtoregM,
    input  logic [AW-1:0]    writeregW,
    input  logic             regwriteW,
    output logic             stallM,
    output logic             stallW,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_t;

    mdState_t      state, stateNext;
    logic [CW-1:0] cnt, cntNext, loadVal;
    logic          lwStall, brStall, stallMd;
    logic          eHitsD, mLateHitsD;

    // Register 0 is hard-wired zero, so it never sources a forward or an interlock.
    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
        else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
        else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;
    end

    assign lwStall = (memtoregE != 2'b00) && regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));

    assign eHitsD     = regwriteE && (writeregE != '0) &&
                        ((writeregE == rsD) || (writeregE == rtD));
    assign mLateHitsD = (memtoregM != 2'b00) && regwriteM && (writeregM != '0) &&
                        ((writeregM == rsD) || (writeregM == rtD));
    assign brStall    = BR_STALL_EN && branchD && (eHitsD || mLateHitsD);

    // mdtypeE is only looked at here, on the issue cycle.
    assign loadVal = mdtypeE ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (mdstartE) begin
                    cntNext   = loadVal;
                    stateNext = (loadVal == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cntNext = cnt - CW'(1);
                if (cnt == CW'(1)) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments with the async reset in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Combinational so E is held on the issue cycle itself, not one cycle late.
    assign stallMd = ((state == IDLE) && mdstartE) || (state == BUSY);
    assign md_busy = stallMd;
    assign md_done = (state == DONE);

    assign stallD = lwStall || brStall || stallMd;
    assign stallF = stallD;
    assign stallE = stallMd;
    assign stallM = stallMd;
    assign stallW = stallMd;
    assign flushE = (lwStall || brStall) && !stallMd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallD && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: dutA (MUL_LAT=1, CNT_W=4) and dutB (BR_STALL_EN=0)
// share stimulus; mul/div latencies are scoreboarded through a queue.
module tb_hazard_sb;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          branchD, regwriteE, mdstartE, mdtypeE, regwriteM, regwriteW;
    logic [1:0]    memtoregE, memtoregM;

    logic       forwardaD, forwardbD, stallF, stallD, stallE, flushE, stallM, stallW;
    logic       md_busy, md_done;
    logic [1:0] forwardaE, forwardbE;
    logic [3:0] stall_cnt;

    logic        forwardaDB, forwardbDB, stallFB, stallDB, stallEB, flushEB, stallMB, stallWB;
    logic        md_busyB, md_doneB;
    logic [1:0]  forwardaEB, forwardbEB;
    logic [15:0] stall_cntB;

    int checks   = 0;
    int failures = 0;
    int expLat[$];

    always #5 clk = ~clk;

    hazard_sb #(.AW(AW), .MUL_LAT(1), .DIV_LAT(32), .CNT_W(4), .BR_STALL_EN(1'b1)) dutA (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .stallF(stallF), .stallD(stallD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .mdstartE(mdstartE), .mdtypeE(mdtypeE),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .stallE(stallE), .flushE(flushE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW), .stallM(stallM), .stallW(stallW),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_sb #(.AW(AW), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(16), .BR_STALL_EN(1'b0)) dutB (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .forwardaD(forwardaDB), .forwardbD(forwardbDB), .stallF(stallFB), .stallD(stallDB),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .mdstartE(mdstartE), .mdtypeE(mdtypeE),
        .forwardaE(forwardaEB), .forwardbE(forwardbEB), .stallE(stallEB), .flushE(flushEB),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW), .stallM(stallMB), .stallW(stallWB),
        .md_busy(md_busyB), .md_done(md_doneB), .stall_cnt(stall_cntB)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        branchD = 1'b0; regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        mdstartE = 1'b0; mdtypeE = 1'b0; memtoregE = 2'b00; memtoregM = 2'b00;
    endtask

    // Called at negedge+1 on the issue cycle; returns at negedge+1 of the md_done cycle.
    task automatic waitDone(input int flipAt, output int stallCycles, output bit sawDone);
        stallCycles = 0;
        sawDone     = 1'b0;
        for (int i = 0; i < 200 && !sawDone; i++) begin
            if (md_done === 1'b1) begin
                sawDone = 1'b1;
            end else begin
                if (stallE === 1'b1) stallCycles++;
                if (i == flipAt) mdtypeE = ~mdtypeE;
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic finishMd(input string tag, input int stallCycles, input bit sawDone);
        check({tag, "_done_seen"}, sawDone, 1);
        check({tag, "_stallE_at_done"}, stallE, 0);
        check({tag, "_busy_at_done"}, md_busy, 0);
        check({tag, "_latency"}, stallCycles, expLat.pop_front());
        mdstartE = 1'b0;
        @(negedge clk); #1;
        check({tag, "_no_retrigger_busy"}, md_busy, 0);
        check({tag, "_done_one_cycle"}, md_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int  cyc;
        bit  done;
        int  expCnt;

        // Reset state; forwards and the issue-cycle busy stay live during reset.
        rst = 1'b1;
        clearInputs();
        mdstartE = 1'b1;
        rsE = 5; writeregM = 5; regwriteM = 1'b1;
        @(negedge clk); #1;
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_md_done", md_done, 0);
        check("rst_md_busy_comb", md_busy, 1);
        check("rst_forwardaE", forwardaE, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        #1;
        check("rel_md_busy", md_busy, 0);
        check("rel_stallD", stallD, 0);
        check("rel_stall_cnt", stall_cnt, 0);

        // Forward priority M over W, and register 0 exclusion.
        @(negedge clk);
        rsE = 5; rtE = 5; writeregM = 5; writeregW = 5; regwriteM = 1'b1; regwriteW = 1'b1;
        #1;
        check("fwdE_m_a", forwardaE, 2'b10);
        check("fwdE_m_b", forwardbE, 2'b10);
        regwriteM = 1'b0; #1;
        check("fwdE_w_a", forwardaE, 2'b01);
        check("fwdE_w_b", forwardbE, 2'b01);
        rsE = 0; rtE = 0; writeregW = 0; #1;
        check("fwdE_r0_a", forwardaE, 2'b00);
        check("fwdE_r0_b", forwardbE, 2'b00);
        clearInputs();
        rsD = 7; rtD = 3; writeregM = 7; regwriteM = 1'b1; #1;
        check("fwdD_a", forwardaD, 1);
        check("fwdD_b_miss", forwardbD, 0);
        rsD = 0; writeregM = 0; #1;
        check("fwdD_r0", forwardaD, 0);

        // Load-use interlock and the stall counter.
        @(negedge clk);
        clearInputs();
        memtoregE = 2'b01; regwriteE = 1'b1; writeregE = 8; rsD = 8;
        #1;
        check("lw_stallF", stallF, 1);
        check("lw_stallD", stallD, 1);
        check("lw_flushE", flushE, 1);
        check("lw_stallE", stallE, 0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk); #1;
            check("lw_stall_cnt", stall_cnt, n);
        end
        writeregE = 0; rsD = 0; #1;
        check("lw_r0_stallD", stallD, 0);

        // Branch interlocks; dutB has the branch stall disabled.
        @(negedge clk);
        clearInputs();
        branchD = 1'b1; rsD = 9; writeregE = 9; regwriteE = 1'b1;
        #1;
        check("br_e_stallD", stallD, 1);
        check("br_e_flushE", flushE, 1);
        check("br_e_stallE", stallE, 0);
        check("br_disabled_stallD", stallDB, 0);
        check("br_disabled_flushE", flushEB, 0);
        clearInputs();
        branchD = 1'b1; rtD = 9; memtoregM = 2'b10; regwriteM = 1'b1; writeregM = 9; #1;
        check("br_m_late_stallD", stallD, 1);
        check("br_m_fwdbD", forwardbD, 1);
        memtoregM = 2'b00; #1;
        check("br_m_alu_no_stall", stallD, 0);
        clearInputs();
        branchD = 1'b1; rsD = 0; writeregE = 0; regwriteE = 1'b1; #1;
        check("br_r0_stallD", stallD, 0);

        // Divide; mdtypeE flips mid-operation and must not change the latency.
        @(negedge clk);
        clearInputs();
        mdstartE = 1'b1; mdtypeE = 1'b1;
        expLat.push_back(32);
        #1;
        check("div_issue_busy", md_busy, 1);
        waitDone(4, cyc, done);
        finishMd("div", cyc, done);

        // Multiply with MUL_LAT=1: one stall cycle then DONE.
        @(negedge clk);
        mdstartE = 1'b1; mdtypeE = 1'b0;
        expLat.push_back(1);
        #1;
        waitDone(-1, cyc, done);
        finishMd("mul", cyc, done);

        // Load-use coinciding with a divide issue, then reset at cycle 10 of the divide.
        @(negedge clk);
        clearInputs();
        memtoregE = 2'b01; regwriteE = 1'b1; writeregE = 8; rsD = 8;
        mdstartE = 1'b1; mdtypeE = 1'b1;
        #1;
        check("sim_stallD", stallD, 1);
        check("sim_flushE", flushE, 0);
        check("sim_stallE", stallE, 1);
        memtoregE = 2'b00; regwriteE = 1'b0; writeregE = 0; rsD = 0;
        repeat (9) @(negedge clk);
        #1;
        check("abort_busy_before", md_busy, 1);
        rst = 1'b1; mdstartE = 1'b0;
        #1;
        check("abort_md_busy", md_busy, 0);
        check("abort_stallE", stallE, 0);
        check("abort_stall_cnt", stall_cnt, 0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); #1;
            check("abort_no_done", md_done, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Saturation: 4-bit counter stops at 15, 16-bit counter keeps counting.
        memtoregE = 2'b01; regwriteE = 1'b1; writeregE = 8; rtD = 8;
        expCnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            expCnt = (expCnt < 15) ? expCnt + 1 : 15;
            check("sat_stall_cnt", stall_cnt, expCnt);
            if (n == 20) check("wide_stall_cnt", stall_cnt, 15);
            if (n == 20) check("wide_stall_cntB", stall_cntB, 20);
        end

        // Reissued divide after the abort runs its full latency.
        @(negedge clk);
        clearInputs();
        mdstartE = 1'b1; mdtypeE = 1'b1;
        expLat.push_back(32);
        #1;
        waitDone(-1, cyc, done);
        finishMd("reissue", cyc, done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
